// File: rtl/uart_rx_core_if.sv
// uart_rx_core_if: config, serial input and received-byte outputs of the UART receiver.
interface uart_rx_core_if;
    logic [15:0] bit_time;
    logic        parity_en;
    logic        parity_odd;
    logic        rx;
    logic [7:0]  data;
    logic        valid;
    logic        parity_err;
    logic        frame_err;
    logic        busy;
    modport master (
        output bit_time, parity_en, parity_odd, rx,
        input  data, valid, parity_err, frame_err, busy
    );
    modport slave (
        input  bit_time, parity_en, parity_odd, rx,
        output data, valid, parity_err, frame_err, busy
    );
endinterface

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver recovering start/data/parity/stop framing, LSB first,
// with one-cycle valid strobe and per-byte parity/frame error flags.
module uart_rx_core #(
    parameter int SYNC = 2,
    parameter bit MAJ  = 1
) (
    input logic            i_clk,
    input logic            i_rst,
    uart_rx_core_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;
    state_t      r_state, w_next;
    logic [SYNC-1:0] r_sync;
    logic        r_prev, r_s0, r_s1, r_pe, r_po, r_perr, r_valid, r_perr_o, r_ferr;
    logic [15:0] r_bt, r_cnt, w_c;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift, r_data;
    logic        w_rxs, w_start, w_end, w_pt, w_sample;
    assign w_rxs   = r_sync[SYNC-1];
    assign w_start = r_prev & ~w_rxs;
    assign w_c     = r_bt >> 1;
    assign w_end   = r_cnt == r_bt - 16'd1;
    generate
        if (MAJ) begin : g_maj
            assign w_pt     = r_cnt == w_c + 16'd1;
            assign w_sample = (r_s0 & r_s1) | (r_s0 & w_rxs) | (r_s1 & w_rxs);
        end else begin : g_one
            assign w_pt     = r_cnt == w_c;
            assign w_sample = w_rxs;
        end
    endgenerate
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_start ? START : IDLE;
            START:   w_next = (w_pt && w_sample) ? IDLE : (w_end ? DATA : START);
            DATA:    w_next = (w_end && r_bit == 3'd7) ? (r_pe ? PARITY : STOP) : DATA;
            PARITY:  w_next = w_end ? STOP : PARITY;
            STOP:    w_next = w_pt ? (w_sample ? IDLE : BRK) : STOP;
            BRK:     w_next = w_rxs ? IDLE : BRK;
            default: w_next = IDLE;
        endcase
    end
    // The detect cycle counts as cnt=0 of the start bit, so IDLE preloads 1.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_sync   <= '1;
            r_prev   <= 1'b1;
            r_s0     <= 1'b1;
            r_s1     <= 1'b1;
            r_bt     <= 16'd0;
            r_pe     <= 1'b0;
            r_po     <= 1'b0;
            r_cnt    <= 16'd0;
            r_bit    <= 3'd0;
            r_shift  <= 8'd0;
            r_perr   <= 1'b0;
            r_valid  <= 1'b0;
            r_data   <= 8'd0;
            r_perr_o <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_sync  <= {r_sync[SYNC-2:0], bus.rx};
            r_prev  <= w_rxs;
            r_valid <= 1'b0;
            r_cnt   <= (r_state == IDLE) ? 16'd1 : (w_end ? 16'd0 : r_cnt + 16'd1);
            if (r_cnt == w_c - 16'd1) r_s0 <= w_rxs;
            if (r_cnt == w_c) r_s1 <= w_rxs;
            if (r_state == IDLE && w_start) begin
                r_bt <= bus.bit_time;
                r_pe <= bus.parity_en;
                r_po <= bus.parity_odd;
            end
            if (r_state == START) r_bit <= 3'd0;
            if (r_state == DATA && w_pt) r_shift <= {w_sample, r_shift[7:1]};
            if (r_state == DATA && w_end) r_bit <= r_bit + 3'd1;
            if (r_state == PARITY && w_pt) r_perr <= ^{r_shift, w_sample, r_po};
            if (r_state == STOP && w_pt) begin
                r_valid  <= 1'b1;
                r_data   <= r_shift;
                r_perr_o <= r_perr & r_pe;
                r_ferr   <= ~w_sample;
            end
        end
    end
    assign bus.data       = r_data;
    assign bus.valid      = r_valid;
    assign bus.parity_err = r_perr_o;
    assign bus.frame_err  = r_ferr;
    assign bus.busy       = r_state != IDLE;
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: drives UART frames onto rx and checks received bytes and flags against
// expectations computed from the frame contents.
module tb_uart_rx_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_valid = 0;
    logic [9:0] got_q[$];
    uart_rx_core_if bus();
    uart_rx_core #(.SYNC(2), .MAJ(1)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (bus.valid) begin
            got_q.push_back({bus.data, bus.parity_err, bus.frame_err});
            n_valid++;
        end
    end
    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask
    // Drives one frame; a nonzero stop_lo holds the stop bit low for that many bit times.
    task automatic send_frame(input logic [7:0] d, input int bt, input bit pe, input bit po,
                              input bit pflip, input int stop_lo, input bit scramble,
                              output logic exp_perr);
        logic pbit;
        int   v0;
        v0 = n_valid;
        bus.bit_time   = 16'(bt);
        bus.parity_en  = pe;
        bus.parity_odd = po;
        bus.rx = 1'b0;
        tick(bt);
        if (scramble) begin
            bus.bit_time   = 16'($urandom_range(8, 60));
            bus.parity_en  = 1'($urandom);
            bus.parity_odd = 1'($urandom);
        end
        for (int i = 0; i < 8; i++) begin
            bus.rx = d[i];
            tick(bt);
        end
        pbit = (($countones(d) % 2) == 1) ^ po ^ pflip;
        if (pe) begin
            bus.rx = pbit;
            tick(bt);
        end
        exp_perr = pe && ((($countones(d) + int'(pbit)) % 2) != int'(po));
        if (stop_lo > 0) begin
            bus.rx = 1'b0;
            tick(stop_lo * bt);
            check("break busy held", 32'(bus.busy), 1);
            check("break single valid", 32'(n_valid - v0), 1);
            bus.rx = 1'b1;
            tick(bt);
            check("break released busy", 32'(bus.busy), 0);
        end else begin
            bus.rx = 1'b1;
            tick(bt);
        end
    endtask
    task automatic expect_frame(input string tag, input logic [7:0] d, input logic pe_exp,
                                input logic fe_exp);
        logic [9:0] r;
        if (got_q.size() == 0) check({tag, " valid"}, 0, 1);
        else begin
            r = got_q.pop_front();
            check({tag, " data"}, 32'(r[9:2]), 32'(d));
            check({tag, " perr"}, 32'(r[1]), 32'(pe_exp));
            check({tag, " ferr"}, 32'(r[0]), 32'(fe_exp));
        end
    endtask
    initial begin
        logic       ep;
        logic [7:0] d;
        logic [7:0] exp_d[$];
        logic       exp_p[$];
        logic       exp_f[$];
        int         bt, sl, waited;
        bit         pe, po, pf;
        bus.rx = 1'b1;
        bus.bit_time = 16'd16;
        bus.parity_en = 1'b0;
        bus.parity_odd = 1'b0;
        tick(3);
        check("reset data", 32'(bus.data), 0);
        check("reset valid", 32'(bus.valid), 0);
        check("reset perr", 32'(bus.parity_err), 0);
        check("reset ferr", 32'(bus.frame_err), 0);
        check("reset busy", 32'(bus.busy), 0);
        rst = 1'b0;
        tick(4);
        send_frame(8'hA5, 16, 0, 0, 0, 0, 0, ep);
        tick(16);
        expect_frame("a5", 8'hA5, ep, 0);
        check("a5 perr model", 32'(ep), 0);
        send_frame(8'h03, 16, 1, 0, 0, 0, 0, ep);
        tick(16);
        expect_frame("03 even ok", 8'h03, 0, 0);
        send_frame(8'h03, 16, 1, 0, 1, 0, 0, ep);
        tick(16);
        expect_frame("03 even bad", 8'h03, 1, 0);
        send_frame(8'h55, 16, 0, 0, 0, 3, 0, ep);
        expect_frame("55 break", 8'h55, 0, 1);
        send_frame(8'h12, 16, 0, 0, 0, 0, 0, ep);
        tick(16);
        expect_frame("12 after break", 8'h12, 0, 0);
        bus.rx = 1'b0;
        tick(4);
        bus.rx = 1'b1;
        check("glitch busy rose", 32'(bus.busy), 1);
        waited = 0;
        while (bus.busy && waited < 12) begin
            tick(1);
            waited++;
        end
        check("glitch busy dropped", 32'(bus.busy), 0);
        tick(20);
        check("glitch no valid", 32'(got_q.size()), 0);
        for (int i = 0; i < 32; i++) send_frame(8'(i), 8, 1, 1, 0, 0, 0, ep);
        tick(20);
        check("loopback count", 32'(got_q.size()), 32);
        for (int i = 0; i < 32; i++) expect_frame($sformatf("loop%0d", i), 8'(i), 0, 0);
        bus.bit_time = 16'd16;
        bus.parity_en = 1'b0;
        bus.rx = 1'b0;
        tick(16);
        for (int i = 0; i < 4; i++) begin
            bus.rx = i[0] ? 1'b0 : 1'b1;
            tick(16);
        end
        bus.rx = 1'b0;
        tick(8);
        check("pre-reset busy", 32'(bus.busy), 1);
        rst = 1'b1;
        #1;
        check("async rst data", 32'(bus.data), 0);
        check("async rst busy", 32'(bus.busy), 0);
        check("async rst flags", 32'({bus.valid, bus.parity_err, bus.frame_err}), 0);
        bus.rx = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(40);
        check("aborted no valid", 32'(got_q.size()), 0);
        send_frame(8'hC3, 16, 0, 0, 0, 0, 0, ep);
        tick(16);
        expect_frame("c3 after reset", 8'hC3, 0, 0);
        for (int k = 0; k < 30; k++) begin
            d  = 8'($urandom);
            bt = $urandom_range(8, 24);
            pe = 1'($urandom);
            po = 1'($urandom);
            pf = ($urandom_range(0, 3) == 0);
            sl = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : 0;
            send_frame(d, bt, pe, po, pf, sl, 1, ep);
            exp_d.push_back(d);
            exp_p.push_back(ep);
            exp_f.push_back(sl > 0);
            tick($urandom_range(bt, 2 * bt));
            expect_frame($sformatf("rand%0d", k), exp_d.pop_front(), exp_p.pop_front(),
                         exp_f.pop_front());
        end
        check("no stray valid", 32'(got_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
